// File: rtl/buffer_reader_pkg.sv
// Shared definitions for the FFT result buffer read-out path.
// addr_w() is also used by the capture side so both agree on buffer address width.
package buffer_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_WAIT = 3'd2,
      ST_SEND = 3'd3,
      ST_GAP  = 3'd4,
      ST_FIN  = 3'd5
   } state_e;

   function automatic int addr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_w(input int gap);
      return (gap < 1) ? 1 : $clog2(gap + 1);
   endfunction

endpackage

// File: rtl/buffer_reader_if.sv
// Buffer read port plus valid/ready output stream of the buffer reader.
// master = reader side, slave = buffer RAM and downstream sink.
interface buffer_reader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output rd_en, rd_addr, out_data, out_valid,
      input  rd_data, out_ready
   );

   modport slave (
      input  rd_en, rd_addr, out_data, out_valid,
      output rd_data, out_ready
   );
endinterface

// File: rtl/buffer_reader_pace_counter.sv
// Purpose: load-and-count-down pacing counter for the inter-word idle gap.
// Latency: zero_o reflects the registered count; load takes effect next cycle.
// Backpressure: none; it counts down freely until zero and then holds.
module pace_counter #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/buffer_reader.sv
// Purpose: on a start pulse, stream buffer words 0..N-1 from a sync-read RAM onto valid/ready.
// Latency: rd_en one cycle after start, out_valid two cycles later; 3+GAP cycles per word.
// Backpressure: out_data/out_valid hold while out_ready is low; no further reads are issued.
module buffer_reader
   import buffer_reader_pkg::*;
#(
   parameter int N      = 16,
   parameter int DATA_W = 16,
   parameter int GAP    = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   buffer_reader_if.master  bus,
   output logic             busy_o,
   output logic             done_o
);

   localparam int                ADDR_W  = addr_w(N);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N - 1);
   localparam bit                HAS_GAP = (GAP > 0);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              accept;
   logic              gap_load;
   logic              gap_zero;

   assign accept = out_valid_q & bus.out_ready;

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      gap_load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d   = ST_READ;
               rd_addr_d = '0;
            end
         end
         ST_READ: state_d = ST_WAIT;
         ST_WAIT: begin
            // RAM output is valid at the end of this cycle
            out_data_d  = bus.rd_data;
            out_valid_d = 1'b1;
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            if (accept) begin
               out_valid_d = 1'b0;
               if (rd_addr_q == LAST) begin
                  state_d = ST_FIN;
               end else begin
                  rd_addr_d = rd_addr_q + 1'b1;
                  if (HAS_GAP) begin
                     state_d  = ST_GAP;
                     gap_load = 1'b1;
                  end else begin
                     state_d = ST_READ;
                  end
               end
            end
         end
         ST_GAP: begin
            if (gap_zero) begin
               state_d = ST_READ;
            end
         end
         ST_FIN: begin
            rd_addr_d = '0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rd_addr_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Counter is loaded with GAP-1 so the GAP state lasts exactly GAP cycles
   if (HAS_GAP) begin : g_pace
      localparam int CNT_W = cnt_w(GAP);
      pace_counter #(
         .W (CNT_W)
      ) u_pace (
         .clk        (clk),
         .rst_n      (rst_n),
         .load_i     (gap_load),
         .load_val_i (CNT_W'(GAP - 1)),
         .zero_o     (gap_zero)
      );
   end else begin : g_no_pace
      logic unused_gap_load;
      assign unused_gap_load = gap_load;
      assign gap_zero        = 1'b1;
   end

   assign bus.rd_en     = (state_q == ST_READ);
   assign bus.rd_addr   = rd_addr_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = (state_q == ST_FIN);

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: GAP=0 and GAP=4 instances, each fed by a sync-read RAM model.
module tb_buffer_reader;
   import buffer_reader_pkg::*;

   localparam int N  = 16;
   localparam int DW = 16;
   localparam int AW = addr_w(N);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b1;
   logic start0, busy0, done0;
   logic start4, busy4, done4;

   buffer_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bif0 ();
   buffer_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bif4 ();

   buffer_reader #(.N(N), .DATA_W(DW), .GAP(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start_i(start0), .bus(bif0.master),
      .busy_o(busy0), .done_o(done0)
   );

   buffer_reader #(.N(N), .DATA_W(DW), .GAP(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start_i(start4), .bus(bif4.master),
      .busy_o(busy4), .done_o(done4)
   );

   logic [DW-1:0] mem0 [N];
   logic [DW-1:0] mem4 [N];

   always @(posedge clk) if (bif0.rd_en) bif0.rd_data <= mem0[bif0.rd_addr];
   always @(posedge clk) if (bif4.rd_en) bif4.rd_data <= mem4[bif4.rd_addr];

   int checks = 0;
   int errors = 0;

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      start0 = 1'b0;
      start4 = 1'b0;
      bif0.out_ready = 1'b0;
      bif4.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      logic [DW+AW+3:0] obs;
      logic [AW+2:0]    o2;
      start0 = 1'b0; start4 = 1'b0;
      bif0.out_ready = 1'b0; bif4.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      obs = {bif0.rd_en, bif0.rd_addr, bif0.out_valid, bif0.out_data, busy0, done0};
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_state_gap0: got %h want 0", obs); end
      obs = {bif4.rd_en, bif4.rd_addr, bif4.out_valid, bif4.out_data, busy4, done4};
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_state_gap4: got %h want 0", obs); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      obs = {bif0.rd_en, bif0.rd_addr, bif0.out_valid, bif0.out_data, busy0, done0};
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL idle_state: got %h want 0", obs); end
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      o2 = {bif0.rd_en, bif0.rd_addr, bif0.out_valid, busy0};
      checks++;
      if (o2 !== {1'b1, {AW{1'b0}}, 1'b0, 1'b1})
         begin errors++; $display("FAIL first_read: got %h want rd_en=1 addr=0 valid=0 busy=1", o2); end
      @(negedge clk);
      checks++;
      if ({bif0.rd_en, bif0.out_valid, busy0} !== 3'b001)
         begin errors++; $display("FAIL wait_cycle: got %b want 001", {bif0.rd_en, bif0.out_valid, busy0}); end
      @(negedge clk);
      checks++;
      if ({bif0.out_valid, bif0.out_data} !== {1'b1, 16'hA000})
         begin errors++; $display("FAIL first_word: got v=%b d=%h want v=1 d=a000", bif0.out_valid, bif0.out_data); end
      @(negedge clk);
      checks++;
      if ({bif0.out_valid, bif0.out_data, bif0.rd_en} !== {1'b1, 16'hA000, 1'b0})
         begin errors++; $display("FAIL first_word_hold: got v=%b d=%h", bif0.out_valid, bif0.out_data); end
   endtask

   task automatic test_stream;
      int idx, last, done_cnt, done_c, rd_cnt;
      bit fin;
      idx = 0; last = 0; done_cnt = 0; done_c = -1; rd_cnt = 0; fin = 0;
      do_reset();
      bif0.out_ready = 1'b1;
      start0 = 1'b1;
      for (int c = 1; c <= 200 && !fin; c++) begin
         @(negedge clk);
         start0 = 1'b0;
         if (bif0.rd_en) rd_cnt++;
         if (done_c >= 0) begin
            checks++;
            if ({busy0, done0, bif0.rd_addr} !== '0)
               begin errors++; $display("FAIL stream_after_done: busy=%b done=%b addr=%0d want 0", busy0, done0, bif0.rd_addr); end
            fin = 1;
         end else begin
            if (bif0.out_valid) begin
               checks++;
               if (bif0.out_data !== 16'hA000 + 16'(idx))
                  begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", idx, bif0.out_data, 16'hA000 + 16'(idx)); end
               checks++;
               if (c - last != 3)
                  begin errors++; $display("FAIL stream_spacing[%0d]: got %0d want 3", idx, c - last); end
               last = c;
               idx++;
            end
            if (done0) begin
               done_cnt++;
               done_c = c;
               checks++;
               if (c != last + 1 || idx != N || !busy0)
                  begin errors++; $display("FAIL stream_done_timing: cycle %0d want %0d words %0d", c, last + 1, idx); end
            end
         end
      end
      checks++;
      if (!fin) begin errors++; $display("FAIL stream_timeout: got no done want done"); end
      checks++;
      if (rd_cnt != N || idx != N || done_cnt != 1)
         begin errors++; $display("FAIL stream_counts: reads %0d words %0d dones %0d want %0d %0d 1", rd_cnt, idx, done_cnt, N, N); end
   endtask

   task automatic test_backpressure;
      int idx, stall, done_cnt;
      bit fin, stalled;
      idx = 0; stall = 0; done_cnt = 0; fin = 0; stalled = 0;
      do_reset();
      bif0.out_ready = 1'b1;
      start0 = 1'b1;
      for (int c = 1; c <= 300 && !fin; c++) begin
         @(negedge clk);
         start0 = 1'b0;
         if (stalled) begin
            checks++;
            if ({bif0.out_valid, bif0.out_data, bif0.rd_en} !== {1'b1, 16'hA003, 1'b0})
               begin errors++; $display("FAIL bp_hold: got v=%b d=%h rd_en=%b want v=1 d=a003 rd_en=0", bif0.out_valid, bif0.out_data, bif0.rd_en); end
            stalled = 0;
         end
         if (bif0.out_valid) begin
            if (idx == 3 && stall < 5) begin
               bif0.out_ready = 1'b0;
               stall++;
               stalled = 1;
            end else begin
               bif0.out_ready = 1'b1;
               checks++;
               if (bif0.out_data !== 16'hA000 + 16'(idx))
                  begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", idx, bif0.out_data, 16'hA000 + 16'(idx)); end
               idx++;
            end
         end else begin
            bif0.out_ready = 1'b1;
         end
         if (done0) begin
            done_cnt++;
            fin = 1;
         end
      end
      checks++;
      if (!fin || idx != N || stall != 5 || done_cnt != 1)
         begin errors++; $display("FAIL bp_counts: done %0d words %0d stalls %0d want 1 %0d 5", done_cnt, idx, stall, N); end
   endtask

   task automatic test_gap;
      int idx, last, vcnt, done_cnt;
      bit fin;
      idx = 0; last = 0; vcnt = 0; done_cnt = 0; fin = 0;
      do_reset();
      bif4.out_ready = 1'b1;
      start4 = 1'b1;
      for (int c = 1; c <= 400 && !fin; c++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (bif4.out_valid) begin
            vcnt++;
            checks++;
            if (bif4.out_data !== 16'hA000 + 16'(idx))
               begin errors++; $display("FAIL gap_data[%0d]: got %h want %h", idx, bif4.out_data, 16'hA000 + 16'(idx)); end
            checks++;
            if (c - last != ((idx == 0) ? 3 : 7))
               begin errors++; $display("FAIL gap_spacing[%0d]: got %0d want %0d", idx, c - last, (idx == 0) ? 3 : 7); end
            last = c;
            idx++;
         end else if (idx > 0 && idx < N && !busy4) begin
            checks++;
            errors++;
            $display("FAIL gap_busy: got busy=0 want 1 during gap after word %0d", idx);
         end
         if (done4) begin
            done_cnt++;
            fin = 1;
            checks++;
            if (c != last + 1)
               begin errors++; $display("FAIL gap_done_timing: got cycle %0d want %0d", c, last + 1); end
         end
      end
      checks++;
      if (!fin || idx != N || vcnt != N || done_cnt != 1)
         begin errors++; $display("FAIL gap_counts: done %0d words %0d valid_cycles %0d want 1 %0d %0d", done_cnt, idx, vcnt, N, N); end
   endtask

   task automatic test_start_ignored;
      int idx, done_cnt, done_c, extra;
      bit fin, hold, r;
      logic [DW-1:0] hold_d;
      idx = 0; done_cnt = 0; done_c = -1; extra = 0; fin = 0; hold = 0; hold_d = '0;
      do_reset();
      bif0.out_ready = 1'b1;
      start0 = 1'b1;
      for (int c = 1; c <= 600 && !fin; c++) begin
         @(negedge clk);
         start0 = 1'b0;
         if (hold) begin
            checks++;
            if ({bif0.out_valid, bif0.out_data} !== {1'b1, hold_d})
               begin errors++; $display("FAIL si_hold: got v=%b d=%h want v=1 d=%h", bif0.out_valid, bif0.out_data, hold_d); end
            hold = 0;
         end
         if (done_c >= 0) begin
            if (busy0 || bif0.rd_en || bif0.out_valid || done0) extra++;
            if (c >= done_c + 10) fin = 1;
         end else if (done0) begin
            done_cnt++;
            done_c = c;
            start0 = 1'b1;
         end else if (busy0 && $urandom_range(0, 5) == 0) begin
            start0 = 1'b1;
         end
         if (bif0.out_valid) begin
            r = ($urandom_range(0, 3) != 0);
            bif0.out_ready = r;
            if (r) begin
               checks++;
               if (bif0.out_data !== 16'hA000 + 16'(idx))
                  begin errors++; $display("FAIL si_data[%0d]: got %h want %h", idx, bif0.out_data, 16'hA000 + 16'(idx)); end
               idx++;
            end else begin
               hold = 1;
               hold_d = bif0.out_data;
            end
         end else begin
            bif0.out_ready = 1'($urandom_range(0, 1));
         end
      end
      checks++;
      if (!fin || idx != N || done_cnt != 1 || extra != 0)
         begin errors++; $display("FAIL si_counts: done %0d words %0d activity_after_done %0d want 1 %0d 0", done_cnt, idx, extra, N); end
   endtask

   task automatic test_reset_mid;
      logic [DW+AW+3:0] obs;
      int idx;
      bit hit, done_seen;
      idx = 0; hit = 0; done_seen = 0;
      do_reset();
      bif0.out_ready = 1'b1;
      start0 = 1'b1;
      for (int c = 1; c <= 100 && !hit; c++) begin
         @(negedge clk);
         start0 = 1'b0;
         if (done0) done_seen = 1;
         if (bif0.out_valid) begin
            if (idx == 8) begin
               rst_n = 1'b0;
               #1;
               hit = 1;
               obs = {bif0.rd_en, bif0.rd_addr, bif0.out_valid, bif0.out_data, busy0, done0};
               checks++;
               if (obs !== '0) begin errors++; $display("FAIL midreset_outputs: got %h want 0", obs); end
            end
            idx++;
         end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL midreset_timeout: got no word 8 want word 8"); end
      repeat (3) begin @(negedge clk); if (done0) done_seen = 1; end
      rst_n = 1'b1;
      repeat (5) begin @(negedge clk); if (done0 || busy0) done_seen = 1; end
      checks++;
      if (done_seen) begin errors++; $display("FAIL midreset_no_done: got done/busy activity want none"); end
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bif0.out_valid, bif0.out_data} !== {1'b1, 16'hA000})
         begin errors++; $display("FAIL midreset_restart: got v=%b d=%h want v=1 d=a000", bif0.out_valid, bif0.out_data); end
   endtask

   task automatic test_random_frames;
      int idx, done_cnt;
      bit fin, hold, r;
      logic [DW-1:0] hold_d;
      do_reset();
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N; i++) mem0[i] = 16'($urandom);
         idx = 0; done_cnt = 0; fin = 0; hold = 0; hold_d = '0;
         @(negedge clk);
         start0 = 1'b1;
         for (int c = 1; c <= 600 && !fin; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (hold) begin
               checks++;
               if ({bif0.out_valid, bif0.out_data} !== {1'b1, hold_d})
                  begin errors++; $display("FAIL rnd_hold[%0d]: got v=%b d=%h want v=1 d=%h", f, bif0.out_valid, bif0.out_data, hold_d); end
               hold = 0;
            end
            if (bif0.out_valid) begin
               r = ($urandom_range(0, 2) != 0);
               bif0.out_ready = r;
               if (r) begin
                  checks++;
                  if (bif0.out_data !== mem0[idx])
                     begin errors++; $display("FAIL rnd_data[%0d][%0d]: got %h want %h", f, idx, bif0.out_data, mem0[idx]); end
                  idx++;
               end else begin
                  hold = 1;
                  hold_d = bif0.out_data;
               end
            end else begin
               bif0.out_ready = 1'($urandom_range(0, 1));
            end
            if (done0) begin
               done_cnt++;
               fin = 1;
            end
         end
         checks++;
         if (!fin || idx != N || done_cnt != 1)
            begin errors++; $display("FAIL rnd_frame[%0d]: done %0d words %0d want 1 %0d", f, done_cnt, idx, N); end
      end
      for (int i = 0; i < N; i++) mem0[i] = 16'hA000 + 16'(i);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         mem0[i] = 16'hA000 + 16'(i);
         mem4[i] = 16'hA000 + 16'(i);
      end
      test_reset();
      test_stream();
      test_backpressure();
      test_gap();
      test_start_ignored();
      test_reset_mid();
      test_random_frames();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
